// File: rtl/input_deserializer.sv
// Packs a stream of DATA_WIDTH-bit words into DATA_WIDTH*WORDS_PER_LINE-bit lines
// and writes each finished line to consecutive memory addresses from a programmed base.
module input_deserializer #(
    parameter int DATA_WIDTH     = 16,
    parameter int WORDS_PER_LINE = 16,
    parameter int ADDR_WIDTH     = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    input  logic [ADDR_WIDTH-1:0]                num_lines,
    output logic                                 input_rdy,
    input  logic                                 input_vld,
    input  logic [DATA_WIDTH-1:0]                input_data,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
    input  logic                                 mem_gnt,
    output logic                                 busy,
    output logic                                 done
);

    localparam int WCW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [WCW-1:0]                       word_cnt_q;
    logic [ADDR_WIDTH-1:0]                line_cnt_q;
    logic [ADDR_WIDTH-1:0]                base_q;
    logic [ADDR_WIDTH-1:0]                num_q;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] wdata_q;
    logic                                 done_q;

    logic hs;
    logic last_word;
    logic last_line;

    assign hs        = input_vld & input_rdy;
    assign last_word = (word_cnt_q == LAST_WORD);
    assign last_line = (line_cnt_q == (num_q - ADDR_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && (num_lines != '0)) state_d = S_FILL;
            end
            S_FILL: begin
                if (hs && last_word) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_gnt) state_d = last_line ? S_IDLE : S_FILL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        input_rdy = (state_q == S_FILL);
        mem_we    = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
        mem_addr  = mem_we ? (base_q + line_cnt_q) : '0;
        mem_wdata = wdata_q;
        done      = done_q;
    end

    // Line buffer is never cleared between lines; every slot is overwritten before the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            base_q     <= '0;
            num_q      <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= ((state_q == S_IDLE) && start && (num_lines == '0)) ||
                      ((state_q == S_WRITE) && mem_gnt && last_line);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        num_q      <= num_lines;
                        word_cnt_q <= '0;
                        line_cnt_q <= '0;
                    end
                end
                S_FILL: begin
                    if (hs) begin
                        wdata_q[DATA_WIDTH*word_cnt_q +: DATA_WIDTH] <= input_data;
                        word_cnt_q <= last_word ? '0 : word_cnt_q + WCW'(1);
                    end
                end
                S_WRITE: begin
                    if (mem_gnt && !last_line) line_cnt_q <= line_cnt_q + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_input_deserializer.sv
// Self-checking bench for input_deserializer: table of transfers with random handshakes
// scored against a word-queue model, plus hand sequences for reset, zero lines and idle input.
module tb_input_deserializer;

    localparam int DW  = 16;
    localparam int WPL = 16;
    localparam int AW  = 12;
    localparam int LW  = DW * WPL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_lines;
    logic          input_rdy;
    logic          input_vld;
    logic [DW-1:0] input_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          busy;
    logic          done;

    input_deserializer #(.DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_lines  (num_lines),
        .input_rdy  (input_rdy),
        .input_vld  (input_vld),
        .input_data (input_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] n;
        int            vld_pct;
        int            gnt_pct;
        int            gnt_hold;
        bit            midstart;
        bit            seq;
        logic [AW-1:0] exp_last;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } wr_t;

    int n_pass = 0;
    int n_chk  = 0;

    logic [DW-1:0] acc_q[$];
    wr_t           wr_q[$];
    int            step_n        = 0;
    int            last_gnt_step = 0;
    int            done_total    = 0;
    bit            prev_we_wait  = 1'b0;
    bit            prev_done     = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_data;

    vec_t vecs[5];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at posedge+1: drives inputs for the next edge and scores what that edge will do.
    task automatic step(input logic vld, input logic [DW-1:0] d, input logic gnt);
        input_vld  = vld;
        input_data = d;
        mem_gnt    = gnt;
        if (prev_we_wait) begin
            check("we_hold_addr", {mem_we, mem_addr}, {1'b1, prev_addr});
            check("we_hold_wdata", mem_wdata, prev_data);
        end
        if (mem_we) check("rdy_low_in_write", input_rdy, 1'b0);
        if (prev_done) check("done_one_cycle", done, 1'b0);
        if (vld && input_rdy) acc_q.push_back(d);
        if (mem_we && gnt) begin
            wr_q.push_back('{mem_addr, mem_wdata});
            last_gnt_step = step_n;
        end
        if (done) done_total++;
        prev_we_wait = mem_we && !gnt;
        prev_addr    = mem_addr;
        prev_data    = mem_wdata;
        prev_done    = done;
        @(posedge clk);
        #1;
        step_n++;
    endtask

    task automatic xfer(input vec_t v);
        int            hold;
        int            we_first;
        int            done_before;
        logic          g;
        logic          vl;
        logic [DW-1:0] dd;
        logic [LW-1:0] exp_d;
        logic [AW-1:0] exp_a;
        acc_q.delete();
        wr_q.delete();
        hold     = v.gnt_hold;
        we_first = 0;
        base_addr = v.base;
        num_lines = v.n;
        start     = 1'b1;
        step(1'b0, '0, 1'b0);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        done_before = done_total;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (v.midstart && c == 20) begin
                start     = 1'b1;
                base_addr = 12'h100;
                num_lines = 12'd5;
            end
            vl = ($urandom_range(99) < v.vld_pct);
            dd = v.seq ? DW'(acc_q.size()) : DW'($urandom);
            g  = ($urandom_range(99) < v.gnt_pct);
            if (mem_we && wr_q.size() == 0) begin
                we_first++;
                if (v.gnt_hold > 0) begin
                    g = (hold == 0);
                    if (hold > 0) hold--;
                end
            end
            step(vl, dd, g);
            start = 1'b0;
        end
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("no_early_done", done_total, done_before);
        check("done_latency", step_n, last_gnt_step + 1);
        check("word_count", acc_q.size(), WPL * int'(v.n));
        check("write_count", wr_q.size(), v.n);
        for (int i = 0; i < wr_q.size(); i++) begin
            exp_d = '0;
            for (int j = 0; j < WPL; j++)
                if (WPL * i + j < acc_q.size()) exp_d[DW*j +: DW] = acc_q[WPL*i + j];
            exp_a = v.base + AW'(i);
            check("line_addr", wr_q[i].a, exp_a);
            check("line_data", wr_q[i].d, exp_d);
        end
        if (wr_q.size() > 0) check("last_addr", wr_q[wr_q.size()-1].a, v.exp_last);
        if (v.gnt_hold > 0) check("we_cycles_first", we_first, v.gnt_hold + 1);
    endtask

    initial begin
        logic [LW-1:0] last_line;
        int            we_seen;

        vecs[0] = '{12'h010, 12'd1, 100, 100, 0, 1'b0, 1'b1, 12'h010};
        vecs[1] = '{12'hFFE, 12'd3,  60, 100, 0, 1'b0, 1'b0, 12'h000};
        vecs[2] = '{12'h040, 12'd2, 100, 100, 5, 1'b0, 1'b0, 12'h041};
        vecs[3] = '{12'h200, 12'd4,  70,  50, 0, 1'b1, 1'b0, 12'h203};
        vecs[4] = '{12'h7FF, 12'd2,  80,  70, 0, 1'b0, 1'b0, 12'h800};

        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_lines  = '0;
        input_vld  = 1'b0;
        input_data = '0;
        mem_gnt    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {input_rdy, mem_we, busy, done, mem_addr}, '0);
        check("reset_wdata", mem_wdata, '0);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);

        // Back-to-back: each transfer starts in the done cycle of the previous one.
        for (int i = 0; i < 5; i++) xfer(vecs[i]);

        step(1'b0, '0, 1'b1);
        last_line = mem_wdata;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'hDEAD, 1'b1);
            check("idle_rdy_low", input_rdy, 1'b0);
        end
        check("idle_no_capture", mem_wdata, last_line);

        base_addr = 12'h050;
        num_lines = 12'd0;
        start     = 1'b1;
        step(1'b1, 16'h1234, 1'b1);
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        we_seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_we || busy) we_seen++;
            step(1'b1, 16'h5678, 1'b1);
        end
        check("zero_no_write", we_seen, 0);

        base_addr = 12'h030;
        num_lines = 12'd1;
        start     = 1'b1;
        step(1'b0, '0, 1'b1);
        start = 1'b0;
        for (int k = 0; k < 7; k++) step(1'b1, DW'(16'hA000 + k), 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {input_rdy, mem_we, busy, done, mem_addr}, '0);
        check("midrst_wdata", mem_wdata, '0);
        @(posedge clk);
        #1;
        check("midrst_no_write", mem_we, 1'b0);
        rst_n        = 1'b1;
        prev_we_wait = 1'b0;
        prev_done    = 1'b0;
        step(1'b0, '0, 1'b1);
        xfer('{12'h020, 12'd1, 90, 100, 0, 1'b0, 1'b0, 12'h020});

        step(1'b0, '0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/input_deserializer.md
Name: input_deserializer

Overview:
Stage directly behind the chip-level 16-bit input stream (io_in data/vld, io_out rdy). Accepts 16-bit words over a valid/ready handshake and packs WORDS_PER_LINE of them into one 256-bit line. Writes each completed line to accelerator memory at consecutive addresses from a programmed base, and signals completion to the accelerator control FSM. Lives inside the accelerator, on the user_proj clock domain.

Parameters:
DATA_WIDTH, 16, width of one input word
WORDS_PER_LINE, 16, words packed per memory line (line width = DATA_WIDTH*WORDS_PER_LINE = 256)
ADDR_WIDTH, 12, memory line address width

Ports:
clk  input  1  user_proj clock (io_clk or wb_clk_i via clock mux)
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load transfer
base_addr  input  ADDR_WIDTH  first line address; sampled on accepted start
num_lines  input  ADDR_WIDTH  lines to load; sampled on accepted start
input_rdy  output  1  block can accept input_data this cycle
input_vld  input  1  input_data valid
input_data  input  DATA_WIDTH  input word
mem_we  output  1  line write request
mem_addr  output  ADDR_WIDTH  line write address
mem_wdata  output  256  packed line
mem_gnt  input  1  memory accepts write this cycle (write completes when mem_we & mem_gnt)
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (async, rst_n=0): state IDLE; input_rdy=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0; word and line counters 0.
- States: IDLE, FILL, WRITE.
- IDLE: input_rdy=0, busy=0. start=1 -> latch base_addr/num_lines, clear counters. If num_lines==0 -> stay IDLE, done=1 next cycle, no writes. Else -> FILL.
- FILL: input_rdy=1, busy=1. Handshake = input_vld & input_rdy. Each handshake writes input_data into mem_wdata slice [DATA_WIDTH*k +: DATA_WIDTH], k = word count (first word in bits [15:0]); k increments. Handshake with k==WORDS_PER_LINE-1 -> WRITE next cycle, k returns to 0.
- WRITE: input_rdy=0, mem_we=1, mem_addr = base + line count (mod 2^ADDR_WIDTH, wraps 4095->0). mem_wdata stable. Hold until mem_gnt=1. On grant: if line count == num_lines-1 -> IDLE, done=1 for exactly that next cycle, busy=0; else line count++ -> FILL.
- Throughput: WORDS_PER_LINE accepted cycles + >=1 write cycle per line; no skid buffer, input_rdy drops in WRITE.
- input_vld with input_rdy=0 (IDLE/WRITE): ignored, nothing captured.
- start while busy: ignored; latched base/num_lines unchanged.
- start in same cycle as done: start accepted (done pulse still issued).
- Reset mid-transfer: everything returns to reset values immediately; partial line discarded, no write issued.
- mem_wdata holds last line after transfer until next captured word.

Test Plan:
- base=0x010, num_lines=1, feed 16 words 0x0000..0x000F back-to-back, mem_gnt=1 -> one write, addr 0x010, wdata[15:0]=0x0000, wdata[255:240]=0x000F; done pulse 1 cycle after grant; input_rdy low during WRITE cycle.
- base=0xFFE, num_lines=3, 48 words, random input_vld gaps -> writes at 0xFFE, 0xFFF, 0x000 in order, data packing correct, one done pulse.
- num_lines=2, mem_gnt held low 5 cycles on first write -> mem_we/addr/wdata stable 6 cycles, input_rdy=0 throughout, no words lost, second line correct.
- num_lines=0, start -> no mem_we ever, done=1 exactly next cycle, busy stays 0.
- Assert rst_n=0 after 7 words of line 1 -> outputs reset immediately, no write; new start with base=0x020 loads fresh line correctly.
- Pulse start while busy with base=0x100 -> ignored, original addresses used; input_vld in IDLE -> no capture.
